// File: rtl/distance_smoother_if.sv
// Sample-in / smoothed-position-out bundle for distance_smoother.
interface distance_smoother_if;
   logic        sample_valid;
   logic [31:0] distance_cm;
   logic [9:0]  position;
   logic        pos_valid;
   logic [8:0]  avg_cm;
   logic        busy;
   logic        target_lost;
   logic [7:0]  reject_count;

   modport master (
      output sample_valid, distance_cm,
      input  position, pos_valid, avg_cm, busy, target_lost, reject_count
   );

   modport slave (
      input  sample_valid, distance_cm,
      output position, pos_valid, avg_cm, busy, target_lost, reject_count
   );
endinterface

// File: rtl/distance_smoother.sv
// Range-checks and clamps distance samples, averages them over a power-of-two
// window, scales the average to a screen X position with a restoring divider,
// and flags loss of target when no sample is accepted for a while.
module distance_smoother #(
   parameter int unsigned WIN_LOG2       = 2,
   parameter int unsigned MIN_CM         = 5,
   parameter int unsigned MAX_CM         = 60,
   parameter int unsigned REJECT_CM      = 400,
   parameter int unsigned POS_MAX        = 639,
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input logic               clk,
   input logic               rst,
   distance_smoother_if.slave bus
);

   localparam int unsigned CM_W    = 9;
   localparam int unsigned POS_W   = 10;
   localparam int unsigned SUM_W   = CM_W + WIN_LOG2;
   localparam int unsigned DEPTH   = 1 << WIN_LOG2;
   localparam int unsigned SPAN    = MAX_CM - MIN_CM;
   localparam int unsigned NUM_W   = $clog2(SPAN * POS_MAX + 1);
   localparam int unsigned DIV_W   = $clog2(SPAN + 1);
   localparam int unsigned TRIAL_W = DIV_W + 1;
   localparam int unsigned STEP_W  = $clog2(NUM_W);
   localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCUM  = 2'd1;
   localparam logic [1:0] S_DIVIDE = 2'd2;
   localparam logic [1:0] S_OUTPUT = 2'd3;

   logic [1:0]         state, state_nxt;
   logic [CM_W-1:0]    sample_q;
   logic               prime_q;
   logic [CM_W-1:0]    ring [DEPTH];
   logic [SUM_W-1:0]   sum_q;
   logic [WIN_LOG2-1:0] wr_ptr;
   logic [CM_W-1:0]    avg_q;
   logic [NUM_W-1:0]   quo_q;
   logic [DIV_W-1:0]   rem_q;
   logic [STEP_W-1:0]  step_q;
   logic [TMO_W-1:0]   tmo_q;

   logic               in_range_c, accept_c, reject_c, last_step_c, ge_c;
   logic [CM_W-1:0]    clamp_c, avg_nxt_c;
   logic [SUM_W-1:0]   sum_nxt_c;
   logic [NUM_W-1:0]   num_c, quo_nxt_c;
   logic [TRIAL_W-1:0] trial_c;
   logic [DIV_W-1:0]   rem_nxt_c;

   // Sample classification, clamping, window update and one divider step
   always_comb begin
      in_range_c = (bus.distance_cm != 32'd0) && (bus.distance_cm <= 32'(REJECT_CM));
      accept_c   = (state == S_IDLE) && bus.sample_valid && in_range_c;
      reject_c   = (state == S_IDLE) && bus.sample_valid && !in_range_c;

      if (bus.distance_cm < 32'(MIN_CM))
         clamp_c = CM_W'(MIN_CM);
      else if (bus.distance_cm > 32'(MAX_CM))
         clamp_c = CM_W'(MAX_CM);
      else
         clamp_c = CM_W'(bus.distance_cm);

      if (prime_q)
         sum_nxt_c = SUM_W'(sample_q) << WIN_LOG2;
      else
         sum_nxt_c = sum_q - SUM_W'(ring[wr_ptr]) + SUM_W'(sample_q);
      avg_nxt_c = CM_W'(sum_nxt_c >> WIN_LOG2);
      num_c     = NUM_W'(avg_nxt_c - CM_W'(MIN_CM)) * NUM_W'(POS_MAX);

      trial_c     = {rem_q, quo_q[NUM_W-1]};
      ge_c        = (trial_c >= TRIAL_W'(SPAN));
      rem_nxt_c   = ge_c ? DIV_W'(trial_c - TRIAL_W'(SPAN)) : DIV_W'(trial_c);
      quo_nxt_c   = {quo_q[NUM_W-2:0], ge_c};
      last_step_c = (step_q == STEP_W'(NUM_W - 1));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept_c) state_nxt = S_ACCUM;
         S_ACCUM:  state_nxt = S_DIVIDE;
         S_DIVIDE: if (last_step_c) state_nxt = S_OUTPUT;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Window, divider and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_q         <= '0;
         prime_q          <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) ring[i] <= '0;
         sum_q            <= '0;
         wr_ptr           <= '0;
         avg_q            <= '0;
         quo_q            <= '0;
         rem_q            <= '0;
         step_q           <= '0;
         bus.position     <= '0;
         bus.avg_cm       <= '0;
         bus.pos_valid    <= 1'b0;
         bus.busy         <= 1'b0;
         bus.reject_count <= '0;
      end else begin
         bus.pos_valid <= 1'b0;
         if (reject_c && bus.reject_count != 8'hFF)
            bus.reject_count <= bus.reject_count + 8'd1;
         case (state)
            S_IDLE: begin
               if (accept_c) begin
                  sample_q <= clamp_c;
                  prime_q  <= bus.target_lost;
                  bus.busy <= 1'b1;
               end
            end
            S_ACCUM: begin
               if (prime_q) begin
                  for (int i = 0; i < int'(DEPTH); i++) ring[i] <= sample_q;
               end else begin
                  ring[wr_ptr] <= sample_q;
                  wr_ptr       <= wr_ptr + WIN_LOG2'(1);
               end
               sum_q  <= sum_nxt_c;
               avg_q  <= avg_nxt_c;
               quo_q  <= num_c;
               rem_q  <= '0;
               step_q <= '0;
            end
            S_DIVIDE: begin
               quo_q  <= quo_nxt_c;
               rem_q  <= rem_nxt_c;
               step_q <= step_q + STEP_W'(1);
               if (last_step_c) begin
                  bus.position  <= POS_W'(quo_nxt_c);
                  bus.avg_cm    <= avg_q;
                  bus.pos_valid <= 1'b1;
               end
            end
            default: bus.busy <= 1'b0;
         endcase
      end
   end

   // Loss-of-target timer: cleared by accepted samples, saturates on expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q           <= '0;
         bus.target_lost <= 1'b1;
      end else if (accept_c) begin
         tmo_q           <= '0;
         bus.target_lost <= 1'b0;
      end else if (state == S_ACCUM) begin
         tmo_q <= '0;
      end else if (!bus.target_lost) begin
         if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_q           <= TMO_W'(TIMEOUT_CYCLES);
            bus.target_lost <= 1'b1;
         end else begin
            tmo_q <= tmo_q + TMO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_distance_smoother.sv
// Scoreboard bench for distance_smoother: directed samples push expected
// (avg, position, cycle) entries; a monitor checks every pos_valid pulse.
module tb_distance_smoother;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      int avg;
      int pos;
      int when;
   } exp_t;

   exp_t exp_q[$];

   distance_smoother_if bus();

   distance_smoother #(
      .WIN_LOG2(2), .MIN_CM(5), .MAX_CM(60), .REJECT_CM(400),
      .POS_MAX(639), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pos_valid pulse must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && bus.pos_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pos_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("avg_cm", int'(bus.avg_cm), e.avg);
            chk("position", int'(bus.position), e.pos);
            chk("pos_valid_cycle", cyc, e.when);
            chk("busy_at_pos_valid", int'(bus.busy), 1);
         end
      end
   end

   // One-cycle sample strobe; returns just after the capturing edge
   task automatic drive(input logic [31:0] d);
      @(posedge clk); #1;
      bus.sample_valid = 1'b1;
      bus.distance_cm  = d;
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
      bus.distance_cm  = 32'd0;
   endtask

   task automatic accept(input logic [31:0] d, input int avg, input int pos);
      exp_t e;
      drive(d);
      e.avg  = avg;
      e.pos  = pos;
      e.when = cyc + 17;
      exp_q.push_back(e);
      chk("busy_after_accept", int'(bus.busy), 1);
      chk("target_lost_after_accept", int'(bus.target_lost), 0);
      repeat (22) @(posedge clk);
   endtask

   task automatic reject(input logic [31:0] d, input int cnt);
      drive(d);
      chk("busy_after_reject", int'(bus.busy), 0);
      chk("reject_count", int'(bus.reject_count), cnt);
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.distance_cm  = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_position", int'(bus.position), 0);
      chk("rst_avg_cm", int'(bus.avg_cm), 0);
      chk("rst_pos_valid", int'(bus.pos_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_target_lost", int'(bus.target_lost), 1);
      chk("rst_reject_count", int'(bus.reject_count), 0);
      rst = 1'b0;

      // prime, then window update toward 40
      accept(32'd30, 30, 290);
      accept(32'd40, 32, 313);
      accept(32'd40, 35, 348);
      accept(32'd40, 37, 371);
      accept(32'd40, 40, 406);

      // clamp low: window drains to MIN_CM
      accept(32'd2, 31, 302);
      accept(32'd2, 22, 197);
      accept(32'd2, 13, 92);
      accept(32'd2, 5, 0);

      // clamp high: window fills to MAX_CM
      accept(32'd100, 18, 151);
      accept(32'd100, 32, 313);
      accept(32'd100, 46, 476);
      accept(32'd100, 60, 639);

      // rejection and saturation
      reject(32'd0, 1);
      reject(32'd500, 2);
      for (int i = 0; i < 300; i++) drive(32'd401);
      chk("reject_count_saturated", int'(bus.reject_count), 255);
      chk("position_held", int'(bus.position), 639);
      chk("avg_cm_held", int'(bus.avg_cm), 60);
      chk("target_lost_after_rejects", int'(bus.target_lost), 1);

      // busy drop: second sample during processing is ignored
      begin
         exp_t e;
         drive(32'd20);
         e.avg = 20; e.pos = 174; e.when = cyc + 17;
         exp_q.push_back(e);
         repeat (3) @(posedge clk);
         drive(32'd50);
         chk("busy_during_drop", int'(bus.busy), 1);
         chk("reject_count_unchanged", int'(bus.reject_count), 255);
         repeat (30) @(posedge clk);
         #1;
         chk("target_lost_after_drop", int'(bus.target_lost), 0);
      end

      // timeout then re-prime
      repeat (120) @(posedge clk);
      #1;
      chk("target_lost_timeout", int'(bus.target_lost), 1);
      accept(32'd45, 45, 464);

      // reset during DIVIDE: no pos_valid for the interrupted sample
      drive(32'd33);
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_position", int'(bus.position), 0);
      chk("midrst_avg_cm", int'(bus.avg_cm), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_pos_valid", int'(bus.pos_valid), 0);
      chk("midrst_target_lost", int'(bus.target_lost), 1);
      chk("midrst_reject_count", int'(bus.reject_count), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("busy_idle_after_rst", int'(bus.busy), 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
